// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-word pipeline (stage 0 = ID/EX onward) with per-stage flush, global hold and stage-0 bubble.
// Define CTRL_PIPE_PERF_EN to build the saturating bubble counter; otherwise bubble_count is tied to zero.
module ctrl_pipe #(
  parameter int unsigned CTRL_W = 14,
  parameter int unsigned STAGES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic                     valid_in,
  input  logic                     bubble,
  input  logic                     hold,
  input  logic [STAGES-1:0]        flush,
  input  logic                     clr_count,
  output logic [STAGES*CTRL_W-1:0] ctrl_out,
  output logic [STAGES-1:0]        valid_out,
  output logic [15:0]              bubble_count
);

  localparam int unsigned CNT_W = 16;

  logic [CTRL_W-1:0] word_q [STAGES];
  logic [CTRL_W-1:0] word_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;

  // Per-stage priority: flush, then hold, then bubble (stage 0), then advance.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      word_d[i]  = word_q[i];
      valid_d[i] = valid_q[i];
    end
    if (flush[0]) begin
      word_d[0]  = '0;
      valid_d[0] = 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        word_d[0]  = '0;
        valid_d[0] = 1'b0;
      end else begin
        word_d[0]  = valid_in ? ctrl_in : '0;
        valid_d[0] = valid_in;
      end
    end
    for (int i = 1; i < STAGES; i++) begin
      if (flush[i]) begin
        word_d[i]  = '0;
        valid_d[i] = 1'b0;
      end else if (!hold) begin
        word_d[i]  = word_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) word_q[i] <= '0;
      valid_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) word_q[i] <= word_d[i];
      valid_q <= valid_d;
    end
  end

  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < STAGES; i++) ctrl_out[i*CTRL_W +: CTRL_W] = word_q[i];
  end

  assign valid_out = valid_q;

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment; count saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (bubble && !hold && !flush[0] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bubble_count = cnt_q;
`else
  logic unused_clr;
  assign unused_clr   = clr_count;
  assign bubble_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: randomized and directed self-checking bench for ctrl_pipe against a queue-free array model.
module tb_ctrl_pipe;

  localparam int unsigned CTRL_W = 14;
  localparam int unsigned STAGES = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [CTRL_W-1:0]        ctrl_in;
  logic                     valid_in;
  logic                     bubble;
  logic                     hold;
  logic [STAGES-1:0]        flush;
  logic                     clr_count;
  logic [STAGES*CTRL_W-1:0] ctrl_out;
  logic [STAGES-1:0]        valid_out;
  logic [15:0]              bubble_count;

  int checks = 0;
  int errors = 0;

  // Reference state: one word/valid per stage plus an integer bubble tally.
  logic [CTRL_W-1:0] m_word [STAGES];
  logic              m_valid [STAGES];
  int                m_cnt;

  ctrl_pipe #(.CTRL_W(CTRL_W), .STAGES(STAGES)) dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .bubble(bubble), .hold(hold), .flush(flush), .clr_count(clr_count),
    .ctrl_out(ctrl_out), .valid_out(valid_out), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  function automatic logic [STAGES*CTRL_W-1:0] exp_flat();
    logic [STAGES*CTRL_W-1:0] v;
    v = '0;
    for (int i = 0; i < STAGES; i++) v[i*CTRL_W +: CTRL_W] = m_word[i];
    return v;
  endfunction

  function automatic logic [STAGES-1:0] exp_valid();
    logic [STAGES-1:0] v;
    for (int i = 0; i < STAGES; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef CTRL_PIPE_PERF_EN
    return 16'(m_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < STAGES; i++) begin
      m_word[i]  = '0;
      m_valid[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Drive inputs, take one rising edge, update the model from pre-edge contents, settle 1ns.
  task automatic drive_edge(input logic [CTRL_W-1:0] c, input logic vin, input logic bub,
                            input logic hld, input logic [STAGES-1:0] fl, input logic clr);
    logic [CTRL_W-1:0] nw [STAGES];
    logic              nv [STAGES];
    ctrl_in = c; valid_in = vin; bubble = bub; hold = hld; flush = fl; clr_count = clr;
    @(posedge clk);
    for (int i = 0; i < STAGES; i++) begin
      if (fl[i])      begin nw[i] = '0; nv[i] = 1'b0; end
      else if (hld)   begin nw[i] = m_word[i]; nv[i] = m_valid[i]; end
      else if (i == 0) begin
        if (bub)      begin nw[i] = '0; nv[i] = 1'b0; end
        else          begin nw[i] = vin ? c : '0; nv[i] = vin; end
      end else        begin nw[i] = m_word[i-1]; nv[i] = m_valid[i-1]; end
    end
    for (int i = 0; i < STAGES; i++) begin
      m_word[i] = nw[i]; m_valid[i] = nv[i];
    end
    if (clr) m_cnt = 0;
    else if (bub && !hld && !fl[0] && m_cnt < 65535) m_cnt = m_cnt + 1;
    #1;
  endtask

  task automatic idle_inputs();
    ctrl_in = '0; valid_in = 1'b0; bubble = 1'b0; hold = 1'b0; flush = '0; clr_count = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ctrl_out !== '0) begin errors++; $display("FAIL reset ctrl_out got %h exp 0", ctrl_out); end
    checks++;
    if (valid_out !== '0) begin errors++; $display("FAIL reset valid_out got %b exp 0", valid_out); end
    checks++;
    if (bubble_count !== 16'h0) begin errors++; $display("FAIL reset bubble_count got %h exp 0", bubble_count); end
  endtask

  task automatic test_stream();
    logic [CTRL_W-1:0] seq [3];
    logic [STAGES-1:0] vexp [3];
    seq[0] = 14'h1A5; seq[1] = 14'h0F0; seq[2] = 14'h333;
    vexp[0] = 3'b001; vexp[1] = 3'b011; vexp[2] = 3'b111;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_edge(seq[k], 1'b1, 1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (ctrl_out[k*CTRL_W +: CTRL_W] !== 14'h1A5) begin
        errors++; $display("FAIL stream stage%0d got %h exp 1a5", k, ctrl_out[k*CTRL_W +: CTRL_W]);
      end
      checks++;
      if (valid_out !== vexp[k]) begin errors++; $display("FAIL stream valid_out got %b exp %b", valid_out, vexp[k]); end
      checks++;
      if (ctrl_out !== exp_flat()) begin errors++; $display("FAIL stream ctrl_out got %h exp %h", ctrl_out, exp_flat()); end
    end
  endtask

  task automatic test_bubble();
    logic [CTRL_W-1:0] older;
    logic [15:0]       cnt_before;
    older = m_word[0];
    cnt_before = exp_cnt();
    drive_edge(14'h1A5, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (ctrl_out[CTRL_W-1:0] !== '0 || valid_out[0] !== 1'b0) begin
      errors++; $display("FAIL bubble stage0 got %h/%b exp 0/0", ctrl_out[CTRL_W-1:0], valid_out[0]);
    end
    checks++;
    if (ctrl_out[CTRL_W +: CTRL_W] !== older) begin
      errors++; $display("FAIL bubble stage1 got %h exp %h", ctrl_out[CTRL_W +: CTRL_W], older);
    end
    checks++;
`ifdef CTRL_PIPE_PERF_EN
    if (bubble_count !== cnt_before + 16'd1) begin
      errors++; $display("FAIL bubble count got %h exp %h", bubble_count, cnt_before + 16'd1);
    end
`else
    if (bubble_count !== cnt_before) begin
      errors++; $display("FAIL bubble count got %h exp %h", bubble_count, cnt_before);
    end
`endif
  endtask

  task automatic test_hold_flush();
    logic [CTRL_W-1:0] a, b, c;
    a = 14'h2AA; b = 14'h155; c = 14'h3C3;
    drive_edge(c, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive_edge(b, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive_edge(a, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive_edge(14'h3FF, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0);
    checks++;
    if (ctrl_out !== {c, 14'h0, a}) begin errors++; $display("FAIL hold_flush ctrl_out got %h exp %h", ctrl_out, {c, 14'h0, a}); end
    checks++;
    if (valid_out !== 3'b101) begin errors++; $display("FAIL hold_flush valid_out got %b exp 101", valid_out); end
  endtask

  task automatic test_bubble_hold();
    logic [STAGES*CTRL_W-1:0] before_w;
    logic [STAGES-1:0]        before_v;
    logic [15:0]              before_c;
    before_w = exp_flat(); before_v = exp_valid(); before_c = exp_cnt();
    drive_edge(14'h0AB, 1'b1, 1'b1, 1'b1, '0, 1'b0);
    checks++;
    if (ctrl_out !== before_w || valid_out !== before_v) begin
      errors++; $display("FAIL bubble_hold pipe got %h/%b exp %h/%b", ctrl_out, valid_out, before_w, before_v);
    end
    checks++;
    if (bubble_count !== before_c) begin errors++; $display("FAIL bubble_hold count got %h exp %h", bubble_count, before_c); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_edge(CTRL_W'($urandom), ($urandom_range(3) != 0), ($urandom_range(3) == 0),
                 ($urandom_range(7) == 0), STAGES'($urandom & $urandom & $urandom),
                 ($urandom_range(15) == 0));
      checks++;
      if (ctrl_out !== exp_flat()) begin errors++; $display("FAIL random[%0d] ctrl_out got %h exp %h", n, ctrl_out, exp_flat()); end
      checks++;
      if (valid_out !== exp_valid()) begin errors++; $display("FAIL random[%0d] valid_out got %b exp %b", n, valid_out, exp_valid()); end
      checks++;
      if (bubble_count !== exp_cnt()) begin errors++; $display("FAIL random[%0d] count got %h exp %h", n, bubble_count, exp_cnt()); end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < STAGES; k++) drive_edge(CTRL_W'($urandom) | 14'h1, 1'b1, 1'b1 * (k == 0), 1'b0, '0, 1'b0);
    for (int k = 0; k < STAGES; k++) drive_edge(CTRL_W'($urandom) | 14'h1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ctrl_out !== '0 || valid_out !== '0 || bubble_count !== 16'h0) begin
      errors++; $display("FAIL async_reset got %h/%b/%h exp all zero", ctrl_out, valid_out, bubble_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive_edge(14'h2D2, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (ctrl_out !== {28'h0, 14'h2D2} || valid_out !== 3'b001) begin
      errors++; $display("FAIL post_reset got %h/%b exp %h/001", ctrl_out, valid_out, {28'h0, 14'h2D2});
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 65537; n++) drive_edge(14'h1A5, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (bubble_count !== exp_cnt()) begin errors++; $display("FAIL saturation count got %h exp %h", bubble_count, exp_cnt()); end
    drive_edge(14'h1A5, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    checks++;
    if (bubble_count !== 16'h0) begin errors++; $display("FAIL clear count got %h exp 0", bubble_count); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_bubble();
    test_hold_flush();
    test_bubble_hold();
    test_random();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
